// File: rtl/wb_b3_sram.sv
// wb_b3_sram: Wishbone B3 slave RAM with byte lanes, linear/wrapping bursts and out-of-range error
module wb_b3_sram #(
  parameter int DW = 32,
  parameter int AW = 32,
  parameter int MEM_SIZE_BYTES = 32768,
  parameter int MEM_ADR_WIDTH = 15
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_i,
  input  logic [AW-1:0] wb_adr_i,
  input  logic [DW-1:0] wb_dat_i,
  input  logic [3:0]    wb_sel_i,
  input  logic          wb_we_i,
  input  logic [1:0]    wb_bte_i,
  input  logic [2:0]    wb_cti_i,
  input  logic          wb_cyc_i,
  input  logic          wb_stb_i,
  output logic          wb_ack_o,
  output logic          wb_err_o,
  output logic          wb_rty_o,
  output logic [DW-1:0] wb_dat_o
);
  localparam int WW = MEM_ADR_WIDTH - 2;
  logic [DW-1:0] mem [0:MEM_SIZE_BYTES/4-1];
  logic [AW-3:0] beat_adr, rd_adr, wrap_mask;
  logic burst, req, resp, resp_d, oor;
  logic unused_adr;
  assign unused_adr = ^wb_adr_i[1:0];
  assign wb_rty_o = 1'b0;
  assign req = wb_cyc_i & wb_stb_i;
  assign resp = wb_ack_o | wb_err_o;
  assign wrap_mask = wb_bte_i == 2'b01 ? (AW-2)'(3) :
                     wb_bte_i == 2'b10 ? (AW-2)'(7) :
                     wb_bte_i == 2'b11 ? (AW-2)'(15) : '1;
  // beat_adr is the beat being acked now; during a burst the next beat wraps inside wrap_mask
  assign rd_adr = burst ? (beat_adr & ~wrap_mask) | ((beat_adr + (AW-2)'(1)) & wrap_mask)
                        : wb_adr_i[AW-1:2];
  assign oor = |rd_adr[AW-3:WW];
  assign resp_d = req & (wb_cti_i == 3'b010 | !resp);
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wb_ack_o <= 1'b0;
      wb_err_o <= 1'b0;
      wb_dat_o <= '0;
      burst <= 1'b0;
      beat_adr <= '0;
    end else begin
      wb_ack_o <= resp_d & !oor;
      wb_err_o <= resp_d & oor;
      burst <= resp_d & wb_cti_i == 3'b010;
      if (resp_d) beat_adr <= rd_adr;
      if (resp_d) wb_dat_o <= oor ? '0 : mem[rd_adr[WW-1:0]];
    end
  end
  always_ff @(posedge wb_clk_i)
    if (!wb_rst_i && req && wb_we_i && wb_ack_o)
      for (int i = 0; i < 4; i++)
        if (wb_sel_i[i]) mem[beat_adr[WW-1:0]][8*i +: 8] <= wb_dat_i[8*i +: 8];
endmodule

// File: tb/tb_wb_b3_sram.sv
// tb_wb_b3_sram: directed checks of classic, burst, byte-lane and error behaviour
module tb_wb_b3_sram;
  logic clk, rst, we, cyc, stb, ack, err, rty;
  logic [31:0] adr, dat_w, dat_r;
  logic [3:0] sel;
  logic [1:0] bte;
  logic [2:0] cti;
  logic [31:0] wdat [16];
  logic [31:0] rdat [16];
  logic [31:0] rd;
  int errors = 0, checks = 0, both = 0, nack, nerr, tail;

  wb_b3_sram dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .wb_adr_i(adr), .wb_dat_i(dat_w), .wb_sel_i(sel),
    .wb_we_i(we), .wb_bte_i(bte), .wb_cti_i(cti), .wb_cyc_i(cyc), .wb_stb_i(stb),
    .wb_ack_o(ack), .wb_err_o(err), .wb_rty_o(rty), .wb_dat_o(dat_r)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(negedge clk) if (ack && err) both++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic classic(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                         output logic [31:0] r, output int na, output int ne);
    adr = a; dat_w = d; sel = s; we = w; cti = 3'b000; bte = 2'b00; cyc = 1'b1; stb = 1'b1;
    for (int i = 0; i < 8 && !(ack || err); i++) begin @(posedge clk); #1; end
    na = int'(ack); ne = int'(err); r = dat_r;
    @(posedge clk); #1;
    na += int'(ack); ne += int'(err);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic burst(input logic w, input logic [31:0] start, input logic [1:0] b, input int n,
                       output int na, output int ne, output int tl);
    logic [31:0] a, m;
    m = b == 2'd1 ? 32'hF : b == 2'd2 ? 32'h1F : b == 2'd3 ? 32'h3F : 32'hFFFF_FFFF;
    a = start; na = 0; ne = 0;
    we = w; bte = b; sel = 4'hF; cyc = 1'b1; stb = 1'b1;
    adr = a; dat_w = wdat[0]; cti = n == 1 ? 3'b111 : 3'b010;
    for (int i = 0; i < 8 && !(ack || err); i++) begin @(posedge clk); #1; end
    for (int k = 0; k < n; k++) begin
      na += int'(ack); ne += int'(err); rdat[k] = dat_r;
      @(posedge clk); #1;
      if (k + 1 < n) begin
        a = (a & ~m) | ((a + 32'd4) & m);
        adr = a; dat_w = wdat[k+1]; cti = k + 2 == n ? 3'b111 : 3'b010;
      end
    end
    tl = int'(ack | err);
    cyc = 1'b0; stb = 1'b0; we = 1'b0; cti = 3'b000; bte = 2'b00;
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; we = 1'b0; cyc = 1'b0; stb = 1'b0; adr = '0; dat_w = '0; sel = '0; bte = '0; cti = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ack", 32'(ack), 0);
    check("rst_err", 32'(err), 0);
    check("rst_rty", 32'(rty), 0);
    check("rst_dat", dat_r, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    classic(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, rd, nack, nerr);
    check("wr_ack_count", 32'(nack), 1);
    classic(1'b0, 32'h10, 32'h0, 4'hF, rd, nack, nerr);
    check("rd_ack_count", 32'(nack), 1);
    check("rd_data", rd, 32'hDEAD_BEEF);

    classic(1'b1, 32'h10, 32'h1122_3344, 4'b0101, rd, nack, nerr);
    classic(1'b0, 32'h10, 32'h0, 4'hF, rd, nack, nerr);
    check("byte_lanes", rd, 32'hDE22_BE44);
    classic(1'b1, 32'h10, 32'hFFFF_FFFF, 4'b0000, rd, nack, nerr);
    check("sel0_ack", 32'(nack), 1);
    classic(1'b0, 32'h10, 32'h0, 4'hF, rd, nack, nerr);
    check("sel0_data", rd, 32'hDE22_BE44);

    adr = 32'h10; dat_w = 32'h0BAD_F00D; sel = 4'hF; we = 1'b1; cti = 3'b000; cyc = 1'b1; stb = 1'b1;
    for (int i = 0; i < 8 && !ack; i++) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_ack", 32'(ack), 0);
    rst = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0;
    @(posedge clk); #1;
    classic(1'b0, 32'h10, 32'h0, 4'hF, rd, nack, nerr);
    check("midrst_data", rd, 32'hDE22_BE44);

    for (int i = 0; i < 4; i++) wdat[i] = 32'(i);
    burst(1'b1, 32'h100, 2'b00, 4, nack, nerr, tail);
    check("lin_wr_acks", 32'(nack), 4);
    check("lin_wr_tail", 32'(tail), 0);
    burst(1'b0, 32'h100, 2'b00, 4, nack, nerr, tail);
    check("lin_rd_acks", 32'(nack), 4);
    check("lin_rd0", rdat[0], 0);
    check("lin_rd1", rdat[1], 1);
    check("lin_rd2", rdat[2], 2);
    check("lin_rd3", rdat[3], 3);
    check("lin_rd_tail", 32'(tail), 0);
    classic(1'b0, 32'h108, 32'h0, 4'hF, rd, nack, nerr);
    check("lin_classic_108", rd, 2);

    classic(1'b1, 32'h200, 32'hAAAA_AAAA, 4'hF, rd, nack, nerr);
    classic(1'b1, 32'h204, 32'hBBBB_BBBB, 4'hF, rd, nack, nerr);
    classic(1'b1, 32'h208, 32'hCCCC_CCCC, 4'hF, rd, nack, nerr);
    classic(1'b1, 32'h20C, 32'hDDDD_DDDD, 4'hF, rd, nack, nerr);
    burst(1'b0, 32'h208, 2'b01, 4, nack, nerr, tail);
    check("wrap4_acks", 32'(nack), 4);
    check("wrap4_0", rdat[0], 32'hCCCC_CCCC);
    check("wrap4_1", rdat[1], 32'hDDDD_DDDD);
    check("wrap4_2", rdat[2], 32'hAAAA_AAAA);
    check("wrap4_3", rdat[3], 32'hBBBB_BBBB);

    classic(1'b1, 32'h7FFC, 32'h55AA_55AA, 4'hF, rd, nack, nerr);
    burst(1'b0, 32'h7FF8, 2'b00, 3, nack, nerr, tail);
    check("end_acks", 32'(nack), 2);
    check("end_errs", 32'(nerr), 1);
    check("end_rd1", rdat[1], 32'h55AA_55AA);
    check("end_rd2", rdat[2], 0);

    classic(1'b1, 32'h0, 32'hCAFE_F00D, 4'hF, rd, nack, nerr);
    classic(1'b0, 32'h0, 32'h0, 4'hF, rd, nack, nerr);
    classic(1'b0, 32'h8000, 32'h0, 4'hF, rd, nack, nerr);
    check("oor_rd_err", 32'(nerr), 1);
    check("oor_rd_ack", 32'(nack), 0);
    check("oor_rd_dat", rd, 0);
    classic(1'b1, 32'h8000, 32'h1234_5678, 4'hF, rd, nack, nerr);
    check("oor_wr_err", 32'(nerr), 1);
    check("oor_wr_ack", 32'(nack), 0);
    classic(1'b0, 32'h0, 32'h0, 4'hF, rd, nack, nerr);
    check("oor_wr_kept", rd, 32'hCAFE_F00D);
    check("ack_err_both", 32'(both), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
